// File: rtl/bubble_pkg.sv
// Shared encodings for the multi-channel bubble data output path:
// access types from the timing generator, the launch tick phase,
// the output FSM states and a channel-pairing helper.
package bubble_pkg;

    localparam logic [2:0] ACC_IDLE    = 3'd0;
    localparam logic [2:0] ACC_BOOT    = 3'd1;
    localparam logic [2:0] ACC_PAGE    = 3'd2;
    localparam logic [1:0] LAUNCH_TICK = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } fsm_state_e;

    // Partner channel when pairs are exchanged; an odd last channel keeps itself.
    function automatic int swap_partner(input int ch, input int n);
        int p;
        p = ch ^ 32'sd1;
        if (p < n) begin
            return p;
        end else begin
            return ch;
        end
    endfunction

endpackage

// File: rtl/bubble_page_ram.sv
// Ping-pong page store: one write port addressed per channel bit,
// one registered read port returning all channels of one bit index.
module bubble_page_ram #(
    parameter int CH_NUM = 4,
    parameter int DEPTH  = 1168,
    parameter int AW     = 11,
    parameter int CH_AW  = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CH_AW-1:0]  wch,
    input  logic              wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [CH_NUM-1:0] rdata
);

    logic [CH_NUM-1:0] mem_q [DEPTH];
    logic [CH_NUM-1:0] rdata_q;

    // Bit-wide write into one channel lane, full-word registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr][wch] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bubble_multich_outbuf.sv
// Multi-channel bubble DOUT path fed from a ping-pong page buffer.
// The loader fills the write bank while the timing generator streams
// the read bank out one bit per launch strobe. Boot accesses mask the
// upper channels to the idle level.
// Optional feature: define BUBBLE_SWAP_EN to add the SWAP input, which
// exchanges channel pairs (0<->1, 2<->3, ...) ahead of boot masking.
module bubble_multich_outbuf
    import bubble_pkg::*;
#(
    parameter int   CH_NUM    = 4,
    parameter int   PAGE_BITS = 584,
    parameter int   BOOT_CH   = 2,
    parameter logic IDLE_LVL  = 1'b1,
    parameter int   CYC_W     = 13,
    localparam int  CH_AW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int  BIT_AW    = $clog2(PAGE_BITS)
) (
    input  logic                    MCLK,
    input  logic                    RST,
    input  logic [2:0]              ACCTYPE,
    input  logic [CYC_W-1:0]        BOUTCYCLENUM,
    input  logic [1:0]              BOUTTICKS,
    input  logic                    nOUTBUFWCLKEN,
    input  logic [CH_AW+BIT_AW-1:0] OUTBUFWADDR,
    input  logic                    OUTBUFWDATA,
    input  logic                    LOADDONE,
`ifdef BUBBLE_SWAP_EN
    input  logic                    SWAP,
`endif
    output logic                    BUFRDY,
    output logic                    UNDERRUN,
    output logic [CH_NUM-1:0]       DOUT
);

    localparam int                RAM_DEPTH = 2 * PAGE_BITS;
    localparam int                RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [CYC_W-1:0]  LAST_IDX  = CYC_W'(PAGE_BITS - 1);
    localparam logic [CH_NUM-1:0] IDLE_WORD = {CH_NUM{IDLE_LVL}};

    logic [1:0]        ticks_q;
    fsm_state_e        state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic              bufrdy_q, bufrdy_d;
    logic              underrun_q, underrun_d;
    logic [CH_NUM-1:0] dout_q, dout_d;
    logic              upd_q, upd_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_boot_q, rd_boot_d;
    logic              rd_last_q, rd_last_d;

    logic              launch_s;
    logic              acc_idle_s;
    logic              in_page_s;
    logic              emit_s;
    logic              bank_free_s;
    logic              wr_en_s;
    logic              ld_ok_s;
    logic [CH_AW-1:0]  wr_ch_s;
    logic [BIT_AW-1:0] wr_bit_s;
    logic [RAM_AW-1:0] waddr_s;
    logic [RAM_AW-1:0] raddr_s;
    logic [CH_NUM-1:0] ram_rdata_s;
    logic [CH_NUM-1:0] lane_s;
    logic [CH_NUM-1:0] word_s;

    // Launch strobe, loader decode and bank addressing.
    always_comb begin
        launch_s    = (BOUTTICKS == LAUNCH_TICK) && (ticks_q != LAUNCH_TICK);
        acc_idle_s  = (ACCTYPE == ACC_IDLE);
        in_page_s   = (int'(BOUTCYCLENUM) < PAGE_BITS);
        wr_ch_s     = OUTBUFWADDR[CH_AW+BIT_AW-1:BIT_AW];
        wr_bit_s    = OUTBUFWADDR[BIT_AW-1:0];
        // The extra full check closes the one-cycle window before BUFRDY
        // catches up with a bank toggle.
        bank_free_s = bufrdy_q && !full_q[wbank_q];
        wr_en_s     = !nOUTBUFWCLKEN && bank_free_s
                      && (int'(wr_ch_s) < CH_NUM) && (int'(wr_bit_s) < PAGE_BITS);
        ld_ok_s     = LOADDONE && bank_free_s;
        if (wbank_q) begin
            waddr_s = RAM_AW'(PAGE_BITS) + RAM_AW'(wr_bit_s);
        end else begin
            waddr_s = RAM_AW'(wr_bit_s);
        end
        if (rbank_q) begin
            raddr_s = RAM_AW'(PAGE_BITS) + RAM_AW'(BOUTCYCLENUM);
        end else begin
            raddr_s = RAM_AW'(BOUTCYCLENUM);
        end
    end

    // Output FSM next state, bank bookkeeping and read pipeline control.
    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        underrun_d = underrun_q;
        emit_s     = 1'b0;
        upd_d      = 1'b0;
        rd_vld_d   = 1'b0;
        rd_boot_d  = rd_boot_q;
        rd_last_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!acc_idle_s) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (acc_idle_s) begin
                    state_d = ST_IDLE;
                end else if (launch_s && (BOUTCYCLENUM == {CYC_W{1'b0}})) begin
                    if (full_q[rbank_q]) begin
                        state_d = ST_STREAM;
                        emit_s  = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_STREAM: begin
                if (acc_idle_s) begin
                    // Abandon the page; the bank stays full so it replays.
                    state_d = ST_IDLE;
                end else if (launch_s) begin
                    if (in_page_s) begin
                        emit_s = 1'b1;
                    end else begin
                        upd_d = 1'b1;
                    end
                    if (BOUTCYCLENUM == LAST_IDX) begin
                        state_d   = ST_ARMED;
                        rd_last_d = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            upd_d     = 1'b1;
            rd_vld_d  = 1'b1;
            rd_boot_d = (ACCTYPE == ACC_BOOT);
        end else begin
            rd_boot_d = rd_boot_q;
        end

        // Release trails the last bit's RAM read by one cycle.
        if (rd_last_q) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
        end else begin
            rbank_d = rbank_q;
        end

        // Release and load always target different banks.
        if (ld_ok_s) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = !wbank_q;
        end else begin
            wbank_d = wbank_q;
        end

        bufrdy_d = !full_q[wbank_q];
    end

`ifdef BUBBLE_SWAP_EN
    logic              rd_swap_q, rd_swap_d;
    logic [CH_NUM-1:0] swapped_s;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_swap
        localparam int PARTNER = swap_partner(g, CH_NUM);
        assign swapped_s[g] = ram_rdata_s[PARTNER];
    end

    // Capture SWAP alongside each emitted bit.
    always_comb begin
        if (emit_s) begin
            rd_swap_d = SWAP;
        end else begin
            rd_swap_d = rd_swap_q;
        end
    end

    // Swap select register.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            rd_swap_q <= 1'b0;
        end else begin
            rd_swap_q <= rd_swap_d;
        end
    end

    assign lane_s = rd_swap_q ? swapped_s : ram_rdata_s;
`else
    assign lane_s = ram_rdata_s;
`endif

    // Boot masking and DOUT next value.
    always_comb begin
        word_s = lane_s;
        for (int c = 0; c < CH_NUM; c++) begin
            if (rd_boot_q && (c >= BOOT_CH)) begin
                word_s[c] = IDLE_LVL;
            end else begin
                word_s[c] = lane_s[c];
            end
        end
        if (acc_idle_s) begin
            dout_d = IDLE_WORD;
        end else if (upd_q && rd_vld_q) begin
            dout_d = word_s;
        end else if (upd_q) begin
            dout_d = IDLE_WORD;
        end else begin
            dout_d = dout_q;
        end
    end

    // All control state and the DOUT register.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            ticks_q    <= 2'd0;
            state_q    <= ST_IDLE;
            full_q     <= 2'b00;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            bufrdy_q   <= 1'b1;
            underrun_q <= 1'b0;
            dout_q     <= IDLE_WORD;
            upd_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_boot_q  <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            ticks_q    <= BOUTTICKS;
            state_q    <= state_d;
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            bufrdy_q   <= bufrdy_d;
            underrun_q <= underrun_d;
            dout_q     <= dout_d;
            upd_q      <= upd_d;
            rd_vld_q   <= rd_vld_d;
            rd_boot_q  <= rd_boot_d;
            rd_last_q  <= rd_last_d;
        end
    end

    bubble_page_ram #(
        .CH_NUM (CH_NUM),
        .DEPTH  (RAM_DEPTH),
        .AW     (RAM_AW),
        .CH_AW  (CH_AW)
    ) u_ram (
        .clk   (MCLK),
        .we    (wr_en_s),
        .waddr (waddr_s),
        .wch   (wr_ch_s),
        .wdata (OUTBUFWDATA),
        .re    (emit_s),
        .raddr (raddr_s),
        .rdata (ram_rdata_s)
    );

    assign BUFRDY   = bufrdy_q;
    assign UNDERRUN = underrun_q;
    assign DOUT     = dout_q;

endmodule

// File: tb/tb_bubble_multich_outbuf.sv
// Directed bench for bubble_multich_outbuf (CH_NUM=4, PAGE_BITS=584).
// Expected DOUT words are pushed when a launch is driven and popped two
// cycles later when the output register should carry them.
module tb_bubble_multich_outbuf;

    logic        MCLK = 1'b0;
    logic        RST;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic [1:0]  BOUTTICKS;
    logic        nOUTBUFWCLKEN;
    logic [11:0] OUTBUFWADDR;
    logic        OUTBUFWDATA;
    logic        LOADDONE;
    logic        SWAP;
    logic        BUFRDY;
    logic        UNDERRUN;
    logic [3:0]  DOUT;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q [$];

    always #5 MCLK = ~MCLK;

    bubble_multich_outbuf #(
        .CH_NUM(4), .PAGE_BITS(584), .BOOT_CH(2), .IDLE_LVL(1'b1), .CYC_W(13)
    ) dut (
        .MCLK          (MCLK),
        .RST           (RST),
        .ACCTYPE       (ACCTYPE),
        .BOUTCYCLENUM  (BOUTCYCLENUM),
        .BOUTTICKS     (BOUTTICKS),
        .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
        .OUTBUFWADDR   (OUTBUFWADDR),
        .OUTBUFWDATA   (OUTBUFWDATA),
        .LOADDONE      (LOADDONE),
`ifdef BUBBLE_SWAP_EN
        .SWAP          (SWAP),
`endif
        .BUFRDY        (BUFRDY),
        .UNDERRUN      (UNDERRUN),
        .DOUT          (DOUT)
    );

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Page contents: page 0 has ch0=1010.., ch3 all ones; page 1 is all-zero where idx%4==0.
    function automatic logic pat(input int pg, input int ch, input int idx);
        if (pg == 0) begin
            case (ch)
                0:       return (idx % 2 == 0) ? 1'b1 : 1'b0;
                1:       return ((idx / 2) % 2 == 1) ? 1'b1 : 1'b0;
                2:       return (idx % 3 == 0) ? 1'b1 : 1'b0;
                default: return 1'b1;
            endcase
        end else begin
            case (ch)
                0:       return (idx % 4 == 1) ? 1'b1 : 1'b0;
                1:       return (idx % 4 == 2) ? 1'b1 : 1'b0;
                2:       return (idx % 4 == 3) ? 1'b1 : 1'b0;
                default: return (idx % 8 == 3) ? 1'b1 : 1'b0;
            endcase
        end
    endfunction

    function automatic logic [3:0] exp_word(input int pg, input int idx, input bit boot, input bit swp);
        logic [3:0] w;
        int src;
        for (int c = 0; c < 4; c++) begin
            src = swp ? (c ^ 1) : c;
            w[c] = pat(pg, src, idx);
            if (boot && c >= 2) w[c] = 1'b1;
        end
        return w;
    endfunction

    task automatic fill_bank(input int pg);
        nOUTBUFWCLKEN = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int b = 0; b < 584; b++) begin
                OUTBUFWADDR = {ch[1:0], b[9:0]};
                OUTBUFWDATA = pat(pg, ch, b);
                tick();
            end
        end
        nOUTBUFWCLKEN = 1'b1;
    endtask

    task automatic load_done();
        LOADDONE = 1'b1;
        tick();
        LOADDONE = 1'b0;
        tick();
    endtask

    // One 4-cycle bit cell; DOUT is checked in the cycle two after the launch.
    task automatic stream_bit(input int idx, input logic [3:0] exp);
        logic [3:0] e;
        exp_q.push_back(exp);
        BOUTCYCLENUM = 13'(idx);
        BOUTTICKS    = 2'd1;
        tick();
        BOUTTICKS    = 2'd2;
        tick();
        e = exp_q.pop_front();
        check($sformatf("dout[%0d]", idx), {28'd0, DOUT}, {28'd0, e});
        BOUTTICKS    = 2'd3;
        tick();
        BOUTTICKS    = 2'd0;
        tick();
    endtask

    initial begin
        bit swp;
        swp = 1'b0;
`ifdef BUBBLE_SWAP_EN
        swp = 1'b1;
`endif
        RST = 1'b1; ACCTYPE = 3'd0; BOUTCYCLENUM = 13'd0; BOUTTICKS = 2'd0;
        nOUTBUFWCLKEN = 1'b1; OUTBUFWADDR = 12'd0; OUTBUFWDATA = 1'b0;
        LOADDONE = 1'b0; SWAP = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();
        check("rst_dout", {28'd0, DOUT}, 32'hF);
        check("rst_bufrdy", {31'd0, BUFRDY}, 32'd1);
        check("rst_underrun", {31'd0, UNDERRUN}, 32'd0);

        // Underrun: page start with both banks empty.
        ACCTYPE = 3'd2;
        tick();
        stream_bit(0, 4'hF);
        check("underrun_set", {31'd0, UNDERRUN}, 32'd1);
        stream_bit(1, 4'hF);
        stream_bit(583, 4'hF);
        check("underrun_sticky", {31'd0, UNDERRUN}, 32'd1);
        ACCTYPE = 3'd0;
        tick();

        // Fill both banks; second load closes the buffer.
        fill_bank(0);
        load_done();
        check("bufrdy_one_full", {31'd0, BUFRDY}, 32'd1);
        fill_bank(1);
        load_done();
        check("bufrdy_both_full", {31'd0, BUFRDY}, 32'd0);
        // Write while closed must be dropped (page 0 bit 0 ch0 is 1).
        nOUTBUFWCLKEN = 1'b0; OUTBUFWADDR = 12'd0; OUTBUFWDATA = 1'b0;
        tick();
        nOUTBUFWCLKEN = 1'b1;

        // Stream page 0 in full.
        ACCTYPE = 3'd2;
        tick();
        for (int i = 0; i < 583; i++) stream_bit(i, exp_word(0, i, 1'b0, 1'b0));
        BOUTCYCLENUM = 13'd583; BOUTTICKS = 2'd1;
        tick();
        BOUTTICKS = 2'd2;
        tick();
        check("dout_last", {28'd0, DOUT}, {28'd0, exp_word(0, 583, 1'b0, 1'b0)});
        check("bufrdy_t2", {31'd0, BUFRDY}, 32'd0);
        BOUTTICKS = 2'd3;
        tick();
        check("bufrdy_t3", {31'd0, BUFRDY}, 32'd1);
        BOUTTICKS = 2'd0;
        tick();

        // Page 1: abandon at index 300, then replay from 0.
        for (int i = 0; i < 300; i++) stream_bit(i, exp_word(1, i, 1'b0, 1'b0));
        BOUTCYCLENUM = 13'd300; BOUTTICKS = 2'd1;
        tick();
        ACCTYPE = 3'd0; BOUTTICKS = 2'd2;
        tick();
        check("abandon_idle", {28'd0, DOUT}, 32'hF);
        BOUTTICKS = 2'd0;
        tick();
        ACCTYPE = 3'd2;
        tick();
        for (int i = 0; i < 584; i++) stream_bit(i, exp_word(1, i, 1'b0, 1'b0));

        // Boot access masks channels 2 and 3.
        fill_bank(1);
        load_done();
        ACCTYPE = 3'd1;
        tick();
        for (int i = 0; i < 584; i++) stream_bit(i, exp_word(1, i, 1'b1, 1'b0));

        // Optional pair swap, then reset mid-stream.
        fill_bank(0);
        load_done();
        ACCTYPE = 3'd2; SWAP = swp;
        tick();
        for (int i = 0; i < 11; i++) stream_bit(i, exp_word(0, i, 1'b0, swp));
        BOUTCYCLENUM = 13'd11; BOUTTICKS = 2'd1;
        tick();
        RST = 1'b1; BOUTTICKS = 2'd2;
        tick();
        check("rst_mid_dout", {28'd0, DOUT}, 32'hF);
        check("rst_mid_bufrdy", {31'd0, BUFRDY}, 32'd1);
        check("rst_mid_underrun", {31'd0, UNDERRUN}, 32'd0);
        RST = 1'b0; BOUTTICKS = 2'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
